rcv_control_unit: RTL and testbench



---
 rtl/rcv_pkg.sv | 24 ++
 rtl/rcu_watchdog.sv | 47 ++++
 rtl/rcv_control_unit.sv | 120 ++++++++++++
 tb/tb_rcv_control_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rcv_pkg
// Purpose  : Shared state encoding and default sizing for the receive control unit.
// Revision : 1.0  initial release
// ============================================================================
package rcv_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 1100;
    localparam int unsigned WD_BITS_DEF        = 11;
    localparam int unsigned ERR_BITS_DEF       = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RECV  = 3'd2,
        STOP  = 3'd3,
        CHECK = 3'd4,
        LOAD  = 3'd5,
        ABORT = 3'd6
    } rcv_state_e;

endpackage
`default_nettype wire

// File: rtl/rcu_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : rcu_watchdog
// Purpose  : Counts cycles spent receiving; flags expiry at TIMEOUT_CYCLES-1.
// Revision : 1.0  initial release
// ============================================================================
module rcu_watchdog
    import rcv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned WD_BITS        = WD_BITS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WD_BITS-1:0] LAST_COUNT = WD_BITS'(TIMEOUT_CYCLES - 1);

    logic [WD_BITS-1:0] count_q;
    logic [WD_BITS-1:0] count_d;

    // Holding at the last value keeps the count from wrapping when
    // TIMEOUT_CYCLES equals 2**WD_BITS.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST_COUNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/rcv_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : rcv_control_unit
// Purpose  : Receive control FSM with packet watchdog and saturating error count.
// Revision : 1.0  initial release
// ============================================================================
module rcv_control_unit
    import rcv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned WD_BITS        = WD_BITS_DEF,
    parameter int unsigned ERR_BITS       = ERR_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_bit_detected,
    input  logic                packet_done,
    input  logic                framing_error,
    input  logic                err_clear,
    output logic                sbc_clear,
    output logic                sbc_enable,
    output logic                enable_timer,
    output logic                load_buffer,
    output logic                rx_busy,
    output logic                timeout_err,
    output logic [ERR_BITS-1:0] err_count
);

    localparam logic [ERR_BITS-1:0] ERR_MAX = {ERR_BITS{1'b1}};

    rcv_state_e          state_q;
    rcv_state_e          state_d;
    logic [ERR_BITS-1:0] err_count_q;
    logic [ERR_BITS-1:0] err_count_d;
    logic                sbc_clear_q;
    logic                sbc_enable_q;
    logic                enable_timer_q;
    logic                load_buffer_q;
    logic                rx_busy_q;
    logic                timeout_err_q;
    logic                wd_expired;
    logic                err_inc;

    rcu_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .WD_BITS        (WD_BITS)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == START),
        .enable  (state_q == RECV),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_bit_detected) state_d = START;
            START:   state_d = RECV;
            RECV: begin
                // A completed packet takes precedence over a same-cycle expiry.
                if (packet_done) begin
                    state_d = STOP;
                end else if (wd_expired) begin
                    state_d = ABORT;
                end
            end
            STOP:    state_d = CHECK;
            CHECK:   state_d = framing_error ? IDLE : LOAD;
            LOAD:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign err_inc = ((state_q == CHECK) && framing_error) || (state_q == ABORT);

    always_comb begin
        err_count_d = err_count_q;
        if (err_clear) begin
            err_count_d = '0;
        end else if (err_inc && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so each registered strobe
    // lines up with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            err_count_q    <= '0;
            sbc_clear_q    <= 1'b0;
            sbc_enable_q   <= 1'b0;
            enable_timer_q <= 1'b0;
            load_buffer_q  <= 1'b0;
            rx_busy_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            err_count_q    <= err_count_d;
            sbc_clear_q    <= (state_d == START);
            sbc_enable_q   <= (state_d == STOP);
            enable_timer_q <= (state_d == RECV);
            load_buffer_q  <= (state_d == LOAD);
            rx_busy_q      <= (state_d != IDLE);
            timeout_err_q  <= (state_d == ABORT);
        end
    end

    assign sbc_clear    = sbc_clear_q;
    assign sbc_enable   = sbc_enable_q;
    assign enable_timer = enable_timer_q;
    assign load_buffer  = load_buffer_q;
    assign rx_busy      = rx_busy_q;
    assign timeout_err  = timeout_err_q;
    assign err_count    = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_rcv_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rcv_control_unit
// Purpose  : Directed, self-checking bench for rcv_control_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_rcv_control_unit;

    // Expected output patterns {sbc_clear, enable_timer, sbc_enable, load_buffer, rx_busy, timeout_err}
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_START = 6'b100010;
    localparam logic [5:0] O_RECV  = 6'b010010;
    localparam logic [5:0] O_STOP  = 6'b001010;
    localparam logic [5:0] O_CHECK = 6'b000010;
    localparam logic [5:0] O_LOAD  = 6'b000110;
    localparam logic [5:0] O_ABORT = 6'b000011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_bit_detected = 1'b0;
    logic packet_done = 1'b0;
    logic framing_error = 1'b0;
    logic err_clear = 1'b0;

    logic       sbc_clear_a, sbc_enable_a, enable_timer_a, load_buffer_a, rx_busy_a, timeout_err_a;
    logic [7:0] err_count_a;
    logic       sbc_clear_s, sbc_enable_s, enable_timer_s, load_buffer_s, rx_busy_s, timeout_err_s;
    logic [1:0] err_count_s;

    logic [5:0] outs_a;
    logic [5:0] outs_s;
    assign outs_a = {sbc_clear_a, enable_timer_a, sbc_enable_a, load_buffer_a, rx_busy_a, timeout_err_a};
    assign outs_s = {sbc_clear_s, enable_timer_s, sbc_enable_s, load_buffer_s, rx_busy_s, timeout_err_s};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rcv_control_unit dut (
        .clk                (clk),
        .rst                (rst),
        .start_bit_detected (start_bit_detected),
        .packet_done        (packet_done),
        .framing_error      (framing_error),
        .err_clear          (err_clear),
        .sbc_clear          (sbc_clear_a),
        .sbc_enable         (sbc_enable_a),
        .enable_timer       (enable_timer_a),
        .load_buffer        (load_buffer_a),
        .rx_busy            (rx_busy_a),
        .timeout_err        (timeout_err_a),
        .err_count          (err_count_a)
    );

    rcv_control_unit #(
        .TIMEOUT_CYCLES (16),
        .WD_BITS        (4),
        .ERR_BITS       (2)
    ) dut_s (
        .clk                (clk),
        .rst                (rst),
        .start_bit_detected (start_bit_detected),
        .packet_done        (packet_done),
        .framing_error      (framing_error),
        .err_clear          (err_clear),
        .sbc_clear          (sbc_clear_s),
        .sbc_enable         (sbc_enable_s),
        .enable_timer       (enable_timer_s),
        .load_buffer        (load_buffer_s),
        .rx_busy            (rx_busy_s),
        .timeout_err        (timeout_err_s),
        .err_count          (err_count_s)
    );

    typedef struct {
        logic       start;
        logic       pd;
        logic       fe;
        logic       clr;
        logic [5:0] exp_o;
        logic [7:0] exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input int cyc, input logic [13:0] got, input logic [13:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got outs=%b err=%0d, expected outs=%b err=%0d",
                     name, cyc, got[13:8], got[7:0], exp[13:8], exp[7:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start_bit_detected = 1'b0;
        packet_done        = 1'b0;
        framing_error      = 1'b0;
        err_clear          = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", 0, {outs_a, err_count_a}, {O_IDLE, 8'd0});
        check("reset_s", 0, {outs_s, 6'd0, err_count_s}, {O_IDLE, 8'd0});
        rst = 1'b0;
    endtask

    // Long frame on the default DUT: start at cycle 5, packet_done at 100.
    task automatic frame_long(input string name, input logic fe_bit);
        logic [5:0] e;
        logic [7:0] ee;
        for (int c = 0; c <= 105; c++) begin
            e = O_IDLE;
            if (c == 6) e = O_START;
            else if (c >= 7 && c <= 100) e = O_RECV;
            else if (c == 101) e = O_STOP;
            else if (c == 102) e = O_CHECK;
            else if (c == 103 && !fe_bit) e = O_LOAD;
            ee = (fe_bit && c >= 103) ? 8'd1 : 8'd0;
            check(name, c, {outs_a, err_count_a}, {e, ee});
            start_bit_detected = (c == 5);
            packet_done        = (c == 100);
            framing_error      = (c == 102) ? fe_bit : 1'b0;
            step();
        end
        clear_inputs();
    endtask

    // Short frame from IDLE; framing_error/err_clear applied in CHECK.
    task automatic run_frame(input logic fe_bit, input logic clr_bit);
        start_bit_detected = 1'b1; step();
        start_bit_detected = 1'b0; step();
        packet_done = 1'b1;        step();
        packet_done = 1'b0;        step();
        framing_error = fe_bit;
        err_clear     = clr_bit;   step();
        clear_inputs();
        if (!fe_bit) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int en_cnt;
        logic [5:0] e;
        logic [7:0] ee;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_IDLE,  8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, O_START, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_RECV,  8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, O_RECV,  8'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, O_RECV,  8'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, O_STOP,  8'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, O_CHECK, 8'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, O_LOAD,  8'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, O_IDLE,  8'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, O_IDLE,  8'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, O_IDLE,  8'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, O_START, 8'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, O_RECV,  8'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, O_STOP,  8'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, O_CHECK, 8'd0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, O_IDLE,  8'd1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, O_IDLE,  8'd1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, O_IDLE,  8'd0};

        // Table: short frames, ignored inputs, framing error and clear
        do_reset();
        for (int i = 0; i < 18; i++) begin
            check("table", i, {outs_a, err_count_a}, {vecs[i].exp_o, vecs[i].exp_err});
            start_bit_detected = vecs[i].start;
            packet_done        = vecs[i].pd;
            framing_error      = vecs[i].fe;
            err_clear          = vecs[i].clr;
            step();
        end
        clear_inputs();

        // Nominal and framing-error long frames
        do_reset();
        frame_long("nominal", 1'b0);
        frame_long("framing", 1'b1);

        // Watchdog abort on the small DUT
        do_reset();
        en_cnt = 0;
        for (int c = 0; c <= 22; c++) begin
            e = O_IDLE;
            if (c == 1) e = O_START;
            else if (c >= 2 && c <= 17) e = O_RECV;
            else if (c == 18) e = O_ABORT;
            ee = (c >= 19) ? 8'd1 : 8'd0;
            check("timeout", c, {outs_s, 6'd0, err_count_s}, {e, ee});
            if (enable_timer_s) en_cnt++;
            start_bit_detected = (c == 0);
            step();
        end
        clear_inputs();
        check("timeout_en_cycles", 0, 14'(en_cnt), 14'd16);

        // packet_done on the expiring cycle wins over the timeout
        for (int c = 0; c <= 22; c++) begin
            e = O_IDLE;
            if (c == 1) e = O_START;
            else if (c >= 2 && c <= 17) e = O_RECV;
            else if (c == 18) e = O_STOP;
            else if (c == 19) e = O_CHECK;
            else if (c == 20) e = O_LOAD;
            check("pd_at_expiry", c, {outs_s, 6'd0, err_count_s}, {e, 8'd1});
            start_bit_detected = (c == 0);
            packet_done        = (c == 17);
            step();
        end
        clear_inputs();

        // Saturation and clear-priority on a 2-bit counter
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            run_frame(1'b1, 1'b0);
            check("saturate", k, {outs_s, 6'd0, err_count_s}, {O_IDLE, 8'((k > 3) ? 3 : k)});
        end
        run_frame(1'b1, 1'b1);
        check("clear_priority", 6, {outs_s, 6'd0, err_count_s}, {O_IDLE, 8'd0});

        // Asynchronous reset in the middle of RECV
        do_reset();
        run_frame(1'b1, 1'b0);
        start_bit_detected = 1'b1; step();
        start_bit_detected = 1'b0; step();
        step();
        check("pre_async_rst", 0, {outs_a, err_count_a}, {O_RECV, 8'd1});
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_a", 0, {outs_a, err_count_a}, {O_IDLE, 8'd0});
        check("async_rst_s", 0, {outs_s, 6'd0, err_count_s}, {O_IDLE, 8'd0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame_long("after_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
